sar_adc_ctrl: RTL and testbench

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_adc_ctrl.sv | 147 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold sampling, one DAC trial per bit,
// result capture with one-cycle done, overrun flagging and abort.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample_hold,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overrun
);

    localparam int MAX_CYCLES = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int BIT_W      = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);
    localparam logic [WIDTH-1:0] CODE_ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        TRIAL,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [BIT_W-1:0] bit_idx, bit_nx;
    logic [WIDTH-1:0] dac_nx, result_nx, kept_code;
    logic             sample_hold_nx, busy_nx, done_nx, overrun_nx;

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        bit_nx         = bit_idx;
        dac_nx         = dac_code;
        result_nx      = result;
        sample_hold_nx = 1'b0;
        busy_nx        = 1'b0;
        done_nx        = 1'b0;
        overrun_nx     = 1'b0;
        kept_code      = dac_code;
        kept_code[bit_idx] = cmp_in;

        case (state)
            IDLE, DONE: begin
                dac_nx = '0;
                if (start) begin
                    state_nx       = SAMPLE;
                    cnt_nx         = SAMPLE_LOAD;
                    sample_hold_nx = 1'b1;
                    busy_nx        = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end

            SAMPLE: begin
                if (abort) begin
                    state_nx = IDLE;
                    dac_nx   = '0;
                end else begin
                    busy_nx    = 1'b1;
                    overrun_nx = start;
                    if (cnt == '0) begin
                        state_nx = TRIAL;
                        cnt_nx   = SETTLE_LOAD;
                        bit_nx   = MSB_IDX;
                        dac_nx   = CODE_ONE << MSB_IDX;
                    end else begin
                        cnt_nx         = cnt - CNT_ONE;
                        sample_hold_nx = 1'b1;
                    end
                end
            end

            TRIAL: begin
                if (abort) begin
                    state_nx = IDLE;
                    dac_nx   = '0;
                end else begin
                    overrun_nx = start;
                    busy_nx    = 1'b1;
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_ONE;
                    end else if (bit_idx == '0) begin
                        state_nx  = DONE;
                        result_nx = kept_code;
                        dac_nx    = '0;
                        done_nx   = 1'b1;
                        busy_nx   = 1'b0;
                    end else begin
                        // Decided bits stay in dac_code; the next lower bit is tried on top of them.
                        bit_nx = bit_idx - BIT_ONE;
                        cnt_nx = SETTLE_LOAD;
                        dac_nx = kept_code | (CODE_ONE << (bit_idx - BIT_ONE));
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                dac_nx   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            dac_code    <= '0;
            result      <= '0;
            sample_hold <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            bit_idx     <= bit_nx;
            dac_code    <= dac_nx;
            result      <= result_nx;
            sample_hold <= sample_hold_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            overrun     <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: directed scenarios plus random start/abort traffic
// compared every cycle against a conversion-timeline reference model.
module tb_sar_adc_ctrl;

    localparam int W = 8;
    localparam int S = 2;
    localparam int T = 2;
    localparam int D = S + W * T + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         cmp_in;
    logic         sample_hold;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overrun;

    int analog;
    int mode;
    int checks = 0;
    int errors = 0;

    // Reference model: conversion timeline position and last result.
    bit m_active;
    int m_t;
    int m_res;
    bit m_ovr;

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cmp_in      (cmp_in),
        .sample_hold (sample_hold),
        .dac_code    (dac_code),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // mode 0: ideal comparator, 1: tied high, 2: tied low
    assign cmp_in = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (analog >= int'(dac_code));

    function automatic bit cmp_model(int code);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return analog >= code;
    endfunction

    // Binary search result with bits W-1 down to 'lowest' decided.
    function automatic int sar_decide(int lowest);
        int c = 0;
        for (int b = W - 1; b >= lowest; b--) begin
            int tr = c | (1 << b);
            if (cmp_model(tr)) c = tr;
        end
        return c;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_res    = 0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_edge();
        if (m_active && m_t >= 1 && m_t < D) begin
            if (abort) begin
                m_active = 1'b0;
                m_ovr    = 1'b0;
            end else begin
                m_ovr = start;
                m_t++;
                if (m_t == D) m_res = sar_decide(0);
            end
        end else begin
            m_ovr = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_t      = 1;
            end else begin
                m_active = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        int exp_dac = 0;
        if (m_active && m_t > S && m_t < D) begin
            int i = W - 1 - (m_t - S - 1) / T;
            exp_dac = sar_decide(i + 1) | (1 << i);
        end
        check("busy",        32'(busy),        32'(m_active && m_t >= 1 && m_t < D));
        check("sample_hold", 32'(sample_hold), 32'(m_active && m_t >= 1 && m_t <= S));
        check("dac_code",    32'(dac_code),    32'(exp_dac));
        check("done",        32'(done),        32'(m_active && m_t == D));
        check("result",      32'(result),      32'(m_res));
        check("overrun",     32'(overrun),     32'(m_ovr));
    endtask

    task automatic step(bit s, bit a);
        start = s;
        abort = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_done;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        analog = 0;
        mode   = 0;
        model_reset();
        #3 compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Ideal comparator at 0xA5, done on the 19th cycle.
        analog = 8'hA5;
        step(1'b1, 1'b0);
        run(D - 1);
        check("done_at_19", 32'(done), 32'd1);
        check("result_a5", 32'(result), 32'hA5);
        run(2);

        // Comparator tied high, then tied low.
        mode = 1;
        step(1'b1, 1'b0);
        run(D - 1);
        check("tied1_result", 32'(result), 32'hFF);
        mode = 2;
        step(1'b1, 1'b0);
        run(D - 1);
        check("tied0_result", 32'(result), 32'h00);
        run(1);
        mode = 0;

        // Re-pulsed start at cycle 5 flags overrun only.
        analog = 8'h5B;
        step(1'b1, 1'b0);
        run(4);
        step(1'b1, 1'b0);
        check("overrun_pulse", 32'(overrun), 32'd1);
        run(D - 6);
        check("overrun_result", 32'(result), 32'h5B);
        run(1);

        // Abort at cycle 7 keeps the prior 0x3C.
        analog = 8'h3C;
        step(1'b1, 1'b0);
        run(D - 1);
        analog = 8'hC7;
        step(1'b1, 1'b0);
        run(6);
        step(1'b0, 1'b1);
        check("abort_busy", 32'(busy), 32'd0);
        run(D);
        check("abort_result", 32'(result), 32'h3C);

        // Start held high: back-to-back conversions, one done per D cycles.
        analog = 8'h71;
        n_done = 0;
        for (int k = 0; k < 3 * D; k++) begin
            step(1'b1, 1'b0);
            if (done) n_done++;
        end
        check("b2b_done_count", 32'(n_done), 32'd3);
        run(1);

        // Abort and start at the same edge while busy: abort wins, no overrun.
        step(1'b1, 1'b0);
        run(3);
        step(1'b1, 1'b1);
        run(2);

        // Abort in the DONE cycle is ignored.
        analog = 8'h19;
        step(1'b1, 1'b0);
        run(D - 1);
        step(1'b0, 1'b1);
        run(1);

        // Reset at cycle 10 discards the conversion; first start after release works.
        analog = 8'hE2;
        step(1'b1, 1'b0);
        run(9);
        async_reset();
        step(1'b1, 1'b0);
        run(D - 1);
        check("post_reset_result", 32'(result), 32'hE2);

        // Random traffic; analog/mode change only while no trial is pending.
        for (int k = 0; k < 800; k++) begin
            if ((!m_active || m_t == D) && $urandom_range(0, 3) == 0) begin
                analog = $urandom_range(0, 255);
                mode   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
